// File: rtl/shake_arbiter_if.sv
// Bundle of requester-side and core-side SHAKE handshake signals for the arbiter.
// The arbiter uses the slave modport; the requesters/core environment uses master.
interface shake_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    req_shake_rst;
  logic [32*NUM_REQ-1:0] req_shake_in;
  logic [NUM_REQ-1:0]    req_in_ready;
  logic [NUM_REQ-1:0]    req_is_last;
  logic [2*NUM_REQ-1:0]  req_byte_num;
  logic [NUM_REQ-1:0]    req_out_ready;
  logic                  shake_rst;
  logic [31:0]           shake_in;
  logic                  shake_in_ready;
  logic                  shake_is_last;
  logic [1:0]            shake_byte_num;
  logic                  shake_out_ready;

  modport master (
    output req, req_shake_rst, req_shake_in, req_in_ready, req_is_last,
           req_byte_num, shake_out_ready,
    input  gnt, req_out_ready, shake_rst, shake_in, shake_in_ready,
           shake_is_last, shake_byte_num
  );

  modport slave (
    input  req, req_shake_rst, req_shake_in, req_in_ready, req_is_last,
           req_byte_num, shake_out_ready,
    output gnt, req_out_ready, shake_rst, shake_in, shake_in_ready,
           shake_is_last, shake_byte_num
  );
endinterface

// File: rtl/shake_arbiter.sv
// Round-robin arbiter sharing one SHAKE256 core between NUM_REQ requesters.
// A grant lasts a whole hash session; the core is held in reset between sessions.
module shake_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic           clk,
  input  logic           rst,
  shake_arbiter_if.slave bus,
  output logic           busy,
  output logic           proto_err
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY,
    RELEASE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   winner;
  logic            found;
  logic            violation;

  logic [2*NUM_REQ-1:0] req_twice;
  logic [NUM_REQ-1:0]   rot;
  logic [IW:0]          offset;
  logic [IW:0]          sum;

  logic [31:0] word_arr [NUM_REQ];
  logic [1:0]  bn_arr   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign word_arr[g] = bus.req_shake_in[32*g +: 32];
    assign bn_arr[g]   = bus.req_byte_num[2*g +: 2];
  end

  // Rotate the request vector so bit 0 is the requester at ptr, then take the
  // first set bit and map its offset back to an absolute requester index.
  always_comb begin
    req_twice = {bus.req, bus.req} >> ptr;
    rot       = req_twice[NUM_REQ-1:0];
    found     = 1'b0;
    offset    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[0]) begin
        found  = 1'b1;
        offset = (IW+1)'(k);
      end
      rot = rot >> 1;
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= (IW+1)'(NUM_REQ)) begin
      sum = sum - (IW+1)'(NUM_REQ);
    end
    winner = sum[IW-1:0];
  end

  assign next_ptr = (owner == IW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Owner is latched when a session is won; ptr moves past the owner on release
  // so a re-requesting owner yields to everyone else that is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= '0;
      ptr   <= '0;
    end else begin
      if (state == IDLE && found) begin
        owner <= winner;
      end
      if (state == RELEASE) begin
        ptr <= next_ptr;
      end
    end
  end

  // Session sequencing: win, flush the core for a cycle, serve, then release.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = GRANT;
      GRANT:   next_state = bus.req[owner] ? BUSY : RELEASE;
      BUSY:    if (!bus.req[owner]) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Core-facing mux: only the owner reaches the core, and only while BUSY;
  // everywhere else the core is held in reset with quiet inputs.
  always_comb begin
    bus.gnt            = '0;
    bus.req_out_ready  = '0;
    bus.shake_rst      = 1'b1;
    bus.shake_in       = '0;
    bus.shake_in_ready = 1'b0;
    bus.shake_is_last  = 1'b0;
    bus.shake_byte_num = '0;
    busy               = (state != IDLE);
    if (state == BUSY) begin
      bus.gnt[owner]           = 1'b1;
      bus.req_out_ready[owner] = bus.shake_out_ready;
      bus.shake_rst            = bus.req_shake_rst[owner];
      bus.shake_in             = word_arr[owner];
      bus.shake_in_ready       = bus.req_in_ready[owner];
      bus.shake_is_last        = bus.req_is_last[owner];
      bus.shake_byte_num       = bn_arr[owner];
    end
  end

  assign violation = |((bus.req_in_ready | bus.req_is_last) & ~bus.gnt);

  // Sticky flag for any requester driving data controls without a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (violation) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shake_arbiter.sv
// Self-checking bench for shake_arbiter with two requesters.
// Words sent by the owner are queued as they are driven and matched at the core side.
module tb_shake_arbiter;

  logic clk;
  logic rst;
  logic busy;
  logic proto_err;

  int passCount;
  int checkCount;

  logic [34:0] sbq[$];
  logic [34:0] sbExp;

  shake_arbiter_if #(.NUM_REQ(2)) bus ();

  shake_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requester 0 drives one word; the expected core-side view is queued.
  task automatic applyStimulus(input logic [31:0] word, input logic last, input logic [1:0] bn);
    bus.req_in_ready[0]       = 1'b1;
    bus.req_is_last[0]        = last;
    bus.req_byte_num[1:0]     = bn;
    bus.req_shake_in[31:0]    = word;
    sbq.push_back({last, bn, word});
  endtask

  task automatic idleRequester0();
    bus.req_in_ready[0]    = 1'b0;
    bus.req_is_last[0]     = 1'b0;
    bus.req_byte_num[1:0]  = 2'd0;
    bus.req_shake_in[31:0] = 32'd0;
  endtask

  // Core-side monitor: every accepted word must match the oldest queued one.
  always @(negedge clk) begin
    if (bus.shake_in_ready) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_unexpected", {63'd0, bus.shake_in_ready}, 64'd0);
      end else begin
        sbExp = sbq.pop_front();
        checkOutput("sb_word", {29'd0, bus.shake_is_last, bus.shake_byte_num, bus.shake_in},
                    {29'd0, sbExp});
      end
    end
  end

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst = 1'b1;
    bus.req             = '0;
    bus.req_shake_rst   = '0;
    bus.req_shake_in    = '0;
    bus.req_in_ready    = '0;
    bus.req_is_last     = '0;
    bus.req_byte_num    = '0;
    bus.shake_out_ready = 1'b0;
    step();
    step();

    checkOutput("rst_gnt", {62'd0, bus.gnt}, 64'd0);
    checkOutput("rst_shake_rst", {63'd0, bus.shake_rst}, 64'd1);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_proto_err", {63'd0, proto_err}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, bus.shake_in_ready}, 64'd0);
    checkOutput("rst_out_ready", {62'd0, bus.req_out_ready}, 64'd0);
    rst = 1'b0;

    // Single requester session streaming 9 words plus a last word.
    bus.req = 2'b01;
    step();
    checkOutput("t2_grant_gnt", {62'd0, bus.gnt}, 64'd0);
    checkOutput("t2_grant_busy", {63'd0, busy}, 64'd1);
    checkOutput("t2_grant_flush", {63'd0, bus.shake_rst}, 64'd1);
    step();
    checkOutput("t2_busy_gnt", {62'd0, bus.gnt}, 64'd1);
    checkOutput("t2_rst_pass_low", {63'd0, bus.shake_rst}, 64'd0);
    bus.req_shake_rst[0] = 1'b1;
    #1;
    checkOutput("t2_rst_pass_high", {63'd0, bus.shake_rst}, 64'd1);
    bus.req_shake_rst[0] = 1'b0;
    for (int w = 0; w < 10; w++) begin
      applyStimulus(32'hC0DE_0000 + 32'(w * 4099), (w == 9), (w == 9) ? 2'd2 : 2'd0);
      step();
    end
    idleRequester0();
    bus.shake_out_ready = 1'b1;
    #1;
    checkOutput("t2_out_ready", {62'd0, bus.req_out_ready}, 64'd1);
    bus.shake_out_ready = 1'b0;
    #1;
    checkOutput("t2_out_ready_low", {62'd0, bus.req_out_ready}, 64'd0);
    bus.req = 2'b00;
    step();
    checkOutput("t2_release_gnt", {62'd0, bus.gnt}, 64'd0);
    checkOutput("t2_release_busy", {63'd0, busy}, 64'd1);
    step();
    checkOutput("t2_idle_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of a session.
    bus.req = 2'b01;
    step();
    step();
    checkOutput("t1_busy_gnt", {62'd0, bus.gnt}, 64'd1);
    applyStimulus(32'h1234_5678, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t1_gnt_drop", {62'd0, bus.gnt}, 64'd0);
    checkOutput("t1_core_rst", {63'd0, bus.shake_rst}, 64'd1);
    checkOutput("t1_in_ready", {63'd0, bus.shake_in_ready}, 64'd0);
    idleRequester0();
    bus.req = 2'b00;
    step();
    rst = 1'b0;

    // Tie from reset: requester 0 first, then 1 three cycles after release.
    bus.req = 2'b11;
    step();
    step();
    checkOutput("t3_first_gnt", {62'd0, bus.gnt}, 64'd1);
    bus.req = 2'b10;
    step();
    checkOutput("t3_release_gnt", {62'd0, bus.gnt}, 64'd0);
    bus.req = 2'b11;
    step();
    checkOutput("t3_idle_gnt", {62'd0, bus.gnt}, 64'd0);
    step();
    checkOutput("t3_grant_gnt", {62'd0, bus.gnt}, 64'd0);
    step();
    checkOutput("t3_second_gnt", {62'd0, bus.gnt}, 64'd2);
    step();
    checkOutput("t3_waiter_holds", {62'd0, bus.gnt}, 64'd2);
    bus.req = 2'b01;
    step();
    step();
    step();
    step();
    checkOutput("t3_waiter_served", {62'd0, bus.gnt}, 64'd1);

    // Fairness: owner 0 drops and re-requests at once while 1 is pending.
    bus.req = 2'b11;
    step();
    bus.req = 2'b10;
    step();
    bus.req = 2'b11;
    step();
    step();
    step();
    checkOutput("t4_alt_10", {62'd0, bus.gnt}, 64'd2);
    bus.req = 2'b01;
    step();
    step();
    step();
    step();
    checkOutput("t4_alt_01", {62'd0, bus.gnt}, 64'd1);
    bus.req = 2'b00;
    step();
    step();

    // Protocol violation by the non-owner.
    bus.req = 2'b01;
    step();
    step();
    checkOutput("t5_owner_gnt", {62'd0, bus.gnt}, 64'd1);
    checkOutput("t5_err_clear", {63'd0, proto_err}, 64'd0);
    bus.req_in_ready[1]     = 1'b1;
    bus.req_shake_in[63:32] = 32'hDEAD_BEEF;
    #1;
    checkOutput("t5_blocked", {63'd0, bus.shake_in_ready}, 64'd0);
    step();
    checkOutput("t5_err_set", {63'd0, proto_err}, 64'd1);
    bus.req_in_ready[1]     = 1'b0;
    bus.req_shake_in[63:32] = 32'd0;
    applyStimulus(32'hFACE_0001, 1'b1, 2'd3);
    step();
    idleRequester0();
    checkOutput("t5_err_sticky", {63'd0, proto_err}, 64'd1);
    bus.req = 2'b00;
    step();
    step();

    // Abandon during GRANT: no grant pulse, ptr still moves past requester 1.
    bus.req = 2'b10;
    step();
    checkOutput("t6_grant_gnt", {62'd0, bus.gnt}, 64'd0);
    checkOutput("t6_grant_busy", {63'd0, busy}, 64'd1);
    bus.req = 2'b00;
    step();
    checkOutput("t6_release_gnt", {62'd0, bus.gnt}, 64'd0);
    step();
    checkOutput("t6_idle_busy", {63'd0, busy}, 64'd0);
    bus.req = 2'b11;
    step();
    step();
    checkOutput("t6_ptr_advanced", {62'd0, bus.gnt}, 64'd1);
    bus.req = 2'b00;
    step();
    step();

    rst = 1'b1;
    #1;
    checkOutput("final_err_cleared", {63'd0, proto_err}, 64'd0);
    step();
    checkOutput("sb_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
